// File: rtl/alu_sequencer.sv
// alu_sequencer: program sequencer for the 3-bit-opcode ALU datapath.
// Host-loaded instruction store and register file; fetch / exec / writeback loop.

package alu_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_XOR  = 3'd5,
      OP_LSL  = 3'd6,
      OP_HALT = 3'd7
   } op_e;

   typedef struct packed {
      op_e        op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
   } instr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WB,
      S_DONE
   } state_e;

endpackage

module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int NUM_INSTR = 16,
   parameter int NUM_REGS  = 8,
   parameter int EXEC_WAIT = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [$clog2(NUM_INSTR):0]   prog_len,
   input  logic                         prog_we,
   input  logic [$clog2(NUM_INSTR)-1:0] prog_addr,
   input  logic [11:0]                  prog_data,
   input  logic                         reg_we,
   input  logic [2:0]                   reg_waddr,
   input  logic [DATA_W-1:0]            reg_wdata,
   input  logic [2:0]                   reg_raddr,
   output logic [DATA_W-1:0]            reg_rdata,
   output logic                         alu_en,
   output logic [2:0]                   alu_ctrl,
   output logic [DATA_W-1:0]            alu_a,
   output logic [DATA_W-1:0]            alu_b,
   input  logic [DATA_W-1:0]            alu_result,
   input  logic                         alu_v,
   input  logic                         alu_c,
   input  logic                         alu_n,
   input  logic                         alu_z,
   output logic [3:0]                   flags,
   output logic [$clog2(NUM_INSTR)-1:0] pc,
   output logic                         busy,
   output logic                         done
);

   localparam int PC_W  = $clog2(NUM_INSTR);
   localparam int LEN_W = PC_W + 1;
   localparam int CNT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

   state_e              state_q;
   state_e              state_d;
   logic [PC_W-1:0]     pc_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    len_clamp;
   logic [LEN_W-1:0]    pc_next;
   logic                last;
   op_e                 ir_op_q;
   logic [2:0]          ir_rd_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [3:0]          flags_q;
   logic [3:0]          flags_d;
   logic [2:0]          ctrl_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [11:0]         imem [NUM_INSTR];
   instr_t              fetch;
   logic                wb_we;
   logic                host_we;
   logic                is_nop;
   logic                is_add;
   logic                is_sub;
   logic                is_halt;

   assign len_clamp = (prog_len > LEN_W'(NUM_INSTR)) ?
                      LEN_W'(NUM_INSTR) : prog_len;
   assign pc_next   = {1'b0, pc_q} + LEN_W'(1);
   assign last      = (pc_next == len_q);
   assign fetch     = instr_t'(imem[pc_q]);
   assign host_we   = reg_we && (state_q == S_IDLE);

   assign is_nop    = (ir_op_q == OP_NOP);
   assign is_add    = (ir_op_q == OP_ADD);
   assign is_sub    = (ir_op_q == OP_SUB);
   assign is_halt   = (ir_op_q == OP_HALT);

   // Program store has no reset; only the host can fill it, and only when idle.
   always_ff @(posedge clk) begin
      if (prog_we && (state_q == S_IDLE)) begin
         imem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (len_clamp == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            if (cnt_q == CNT_W'(EXEC_WAIT - 1)) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            if (is_halt || last) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ADD owns v/c, SUB owns n/z; everything else leaves flags alone.
   always_comb begin
      flags_d = flags_q;
      wb_we   = 1'b0;
      if (state_q == S_WB) begin
         unique case (1'b1)
            is_nop, is_halt: ;
            is_add: begin
               flags_d[3:2] = {alu_v, alu_c};
               wb_we        = 1'b1;
            end
            is_sub: begin
               flags_d[1:0] = {alu_n, alu_z};
               wb_we        = 1'b1;
            end
            default: wb_we = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         len_q   <= '0;
         ir_op_q <= OP_NOP;
         ir_rd_q <= '0;
         cnt_q   <= '0;
         flags_q <= '0;
         ctrl_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         flags_q <= flags_d;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  pc_q  <= '0;
                  len_q <= len_clamp;
               end
            end
            S_FETCH: begin
               ir_op_q <= fetch.op;
               ir_rd_q <= fetch.rd;
               ctrl_q  <= fetch.op;
               a_q     <= rf_q[fetch.rs1];
               b_q     <= rf_q[fetch.rs2];
               cnt_q   <= '0;
            end
            S_EXEC: cnt_q <= cnt_q + CNT_W'(1);
            S_WB: begin
               // pc saturates at the last slot; only start rewinds it
               if (!is_halt && (pc_q != PC_W'(NUM_INSTR - 1))) begin
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_we) begin
         rf_q[ir_rd_q] <= alu_result;
      end else if (host_we) begin
         rf_q[reg_waddr] <= reg_wdata;
      end
   end

   assign reg_rdata = rf_q[reg_raddr];
   assign alu_en    = (state_q == S_EXEC) || (state_q == S_WB);
   assign alu_ctrl  = ctrl_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign flags     = flags_q;
   assign pc        = pc_q;
   assign busy      = (state_q == S_FETCH) || alu_en;
   assign done      = (state_q == S_DONE);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Program sequencer for the 3-bit-opcode ALU datapath (NOP/ADD/SUB/AND/OR/XOR/LSL). It holds a small instruction store and an 8-entry register file, both loaded by the host. On a start pulse it fetches instructions one at a time, drives the ALU's enable, control and operand inputs, and writes each result and its flags back. It sits between the board-level key/switch interface and the ALU, replacing manual single-command runs.

Parameters:
DATA_W, 32, ALU operand/result width
NUM_INSTR, 16, instruction store depth (program counter 4 bits)
NUM_REGS, 8, register file depth (index 3 bits)
EXEC_WAIT, 1, cycles the ALU inputs are held before the result is sampled (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins program execution from pc=0
prog_len  in  5  number of instructions to run (0..16)
prog_we  in  1  instruction store write strobe
prog_addr  in  4  instruction store write address
prog_data  in  12  {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
reg_we  in  1  host register file write strobe
reg_waddr  in  3  host write index
reg_wdata  in  32  host write data
reg_raddr  in  3  debug read index
reg_rdata  out  32  combinational read of reg[reg_raddr]
alu_en  out  1  ALU enable
alu_ctrl  out  3  ALU opcode
alu_a  out  32  ALU operand 1 (reg[rs1])
alu_b  out  32  ALU operand 2 (reg[rs2])
alu_result  in  32  ALU result
alu_v, alu_c, alu_n, alu_z  in  1 each  ALU flags
flags  out  4  latched {v,c,n,z}
pc  out  4  current instruction index
busy  out  1  high from the cycle after start until DONE exits
done  out  1  one-cycle pulse at program end

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, flags=0, busy=0, done=0, alu_en=0, alu_ctrl=0, alu_a=alu_b=0, all registers 0. Instruction store contents are not reset.
- States: IDLE, FETCH, EXEC, WB, DONE.
- IDLE: start=1 -> FETCH, pc=0, busy=1. If prog_len=0, go to DONE instead.
- FETCH (1 cycle): register the instruction at pc; register alu_a=reg[rs1], alu_b=reg[rs2], alu_ctrl=op. -> EXEC.
- EXEC (EXEC_WAIT cycles, counter): alu_en=1, operands and ctrl held stable. -> WB.
- WB (1 cycle): alu_en stays 1.
  - op 000 (NOP): no writes.
  - Any other op except 111: reg[rd] <= alu_result.
  - ADD (001) updates flags v,c; SUB (010) updates n,z; other flag bits are held.
  - op 111 is HALT: no write; -> DONE.
  - Otherwise pc increments. If the new pc equals prog_len -> DONE, else -> FETCH.
- Per-instruction latency: 2+EXEC_WAIT cycles (3 at default).
- DONE (1 cycle): done=1, busy=0, alu_en=0. -> IDLE. pc holds the last value until the next start.
- alu_en=0 in IDLE, FETCH and DONE.
- Host writes (prog_we, reg_we) are accepted only in IDLE and ignored while busy.
- start while busy is ignored.
- Register hazard: the operands read in FETCH see the WB write of the previous instruction (WB precedes the next FETCH by one cycle); no forwarding is needed.
- rd = rs1 is legal; reg[rd] is overwritten only in WB.
- prog_len > 16 is treated as 16; pc wraps to 0 only via a new start.
- Asserting rst_n mid-program aborts immediately to reset values; the register file is cleared.

Test Plan:
1. Reset, preload r1=5, r2=3, program [ADD r3,r1,r2], prog_len=1, start -> alu_en high for 2 cycles, r3=8, flags=0000, done pulses exactly 4 cycles after start.
2. SUB r4,r2,r1 (3-5) -> r4=0xFFFFFFFE, flags n=1, z=0; then SUB r5,r1,r1 -> r5=0, z=1, n=0, v/c unchanged.
3. ADD r6 = 0x7FFFFFFF+1 -> r6=0x80000000, v=1; next AND r7,r1,r2 -> r7=1, flags unchanged.
4. Program of 5 with HALT at index 2, prog_len=5 -> only indices 0-1 write back, done after index 2, pc=2.
5. prog_len=0 with start -> done one cycle later, no alu_en, registers unchanged; reg_we during busy -> no effect.
6. Drop rst_n during the EXEC of the second instruction -> outputs and registers 0 asynchronously; the next start runs cleanly from pc=0.
